// File: rtl/counter_ts_capture.sv
// Hardware timestamp capture: snapshots `counter` on rising edges of evt_in into a small FWFT FIFO.
// Optional macro TSC_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module counter_ts_capture #(
  parameter int CW    = 32,
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CW-1:0]          counter,
  input  logic                   evt_in,
  input  logic                   cap_en,
  output logic [CW-1:0]          ts_data,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [DW-1:0]          drop_cnt,
  input  logic                   clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [DW-1:0] DROP_MAX = {DW{1'b1}};

  logic          evt_s;
  logic          evt_d_r;
  logic          push_req_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          drop_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          ovf_r;
  logic [DW-1:0] drop_cnt_r;
  logic [CW-1:0] mem_r [DEPTH];

`ifdef TSC_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-flop synchronizer for asynchronous event sources
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= evt_in;
      sync2_r <= sync1_r;
    end
  end

  assign evt_s = sync2_r;
`else
  assign evt_s = evt_in;
`endif

  // Previous event level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_d_r <= 1'b0;
    end else begin
      evt_d_r <= evt_s;
    end
  end

  // Push/pop qualification; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    empty_s    = (level_r == {LW{1'b0}});
    full_s     = (level_r == FULL_LVL);
    push_req_s = evt_s & ~evt_d_r & cap_en;
    pop_s      = ~empty_s & ts_ready;
    push_ok_s  = push_req_s & (~full_s | pop_s);
    drop_s     = push_req_s & full_s & ~pop_s;
  end

  // Storage write; entries are not reset, validity is tracked by level_r
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= counter;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= {DW{1'b0}};
    end else if (drop_s) begin
      ovf_r <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_r <= DW'(1);
      end else if (drop_cnt_r != DROP_MAX) begin
        drop_cnt_r <= drop_cnt_r + DW'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end else if (clr_ovf) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= {DW{1'b0}};
    end else begin
      ovf_r      <= ovf_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // First-word-fall-through head; zero when empty
  always_comb begin
    if (empty_s) begin
      ts_data = {CW{1'b0}};
    end else begin
      ts_data = mem_r[rd_ptr_r];
    end
  end

  assign ts_valid = ~empty_s;
  assign level    = level_r;
  assign ovf      = ovf_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_counter_ts_capture.sv
// Self-checking bench for counter_ts_capture: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_counter_ts_capture;

`ifdef TSC_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] cnt;
  logic        evt_in;
  logic        cap_en;
  logic [31:0] ts_data;
  logic        ts_valid;
  logic        ts_ready;
  logic [2:0]  level;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic        clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_drop;
  bit          m_prev;
  bit          m_hist[2];

  counter_ts_capture #(.CW(32), .DEPTH(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .counter(cnt), .evt_in(evt_in), .cap_en(cap_en),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready), .level(level),
    .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance model with pre-edge inputs, then one clock edge; counter free-runs
  task automatic tick();
    bit es;
    bit push;
    bit pop;
    bit drop;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0; m_drop = 0; m_prev = 1'b0;
      m_hist[0] = 1'b0; m_hist[1] = 1'b0;
    end else begin
      es = (SD == 0) ? evt_in : m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = evt_in;
      push = es && !m_prev && cap_en;
      pop  = (mq.size() > 0) && (ts_ready == 1'b1);
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < 4) mq.push_back(cnt);
        else drop = 1'b1;
      end
      if (drop) begin
        m_ovf  = 1'b1;
        m_drop = clr_ovf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr_ovf) begin
        m_ovf = 1'b0; m_drop = 0;
      end
      m_prev = es;
    end
    @(posedge clk);
    #1;
    cnt = cnt + 32'd1;
  endtask

  task automatic pulse(input logic [31:0] v);
    cnt = v; evt_in = 1'b1; tick();
    evt_in = 1'b0; tick();
    repeat (SD) tick();
  endtask

  task automatic drain_all();
    ts_ready = 1'b1; repeat (5) tick(); ts_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; evt_in = 1'b0; cap_en = 1'b1; ts_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick(); reset = 1'b0;
    n_tests++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", ts_valid); end
    n_tests++; if (ts_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", ts_data); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0h expected 0", ovf); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_single_capture();
    cnt = 32'h100; evt_in = 1'b1; tick();
    for (int i = 0; i < SD; i++) begin
      n_tests++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0h expected 0", ts_valid); end
      tick();
    end
    n_tests++; if (ts_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0h expected 1", ts_valid); end
    n_tests++; if (ts_data !== 32'h100 + SD) begin n_fail++; $display("FAIL single_data: got %0h expected %0h", ts_data, 32'h100 + SD); end
    repeat (4) tick();
    evt_in = 1'b0;
    n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", level); end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    repeat (SD) tick();
    n_tests++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped_valid: got %0h expected 0", ts_valid); end
    n_tests++; if (ts_data !== 32'd0) begin n_fail++; $display("FAIL single_popped_data: got %0h expected 0", ts_data); end
  endtask

  task automatic test_burst_drain();
    logic [31:0] vals[4];
    vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30; vals[3] = 32'd40;
    ts_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(vals[i]);
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL burst_level: got %0d expected 4", level); end
    ts_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ts_data !== vals[i] + SD) begin n_fail++; $display("FAIL burst_pop%0d: got %0h expected %0h", i, ts_data, vals[i] + SD); end
      tick();
    end
    ts_ready = 1'b0;
    n_tests++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL burst_empty_valid: got %0h expected 0", ts_valid); end
    n_tests++; if (ts_data !== 32'd0) begin n_fail++; $display("FAIL burst_empty_data: got %0h expected 0", ts_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 7; i++) pulse(32'(i));
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0h expected 1", ovf); end
    n_tests++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL ovf_drop: got %0d expected 3", drop_cnt); end
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", level); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_flag: got %0h expected 0", ovf); end
    n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clr_drop: got %0d expected 0", drop_cnt); end
    ts_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++; if (ts_data !== 32'(i) + SD) begin n_fail++; $display("FAIL ovf_contents%0d: got %0h expected %0h", i, ts_data, 32'(i) + SD); end
      tick();
    end
    ts_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    logic [31:0] exp[4];
    exp[0] = 32'h22 + SD; exp[1] = 32'h33 + SD; exp[2] = 32'h44 + SD; exp[3] = 32'h55;
    pulse(32'h11); pulse(32'h22); pulse(32'h33); pulse(32'h44);
    cnt = 32'h55 - SD; evt_in = 1'b1;
    repeat (SD) tick();
    ts_ready = 1'b1; tick(); ts_ready = 1'b0; evt_in = 1'b0;
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fullpp_level: got %0d expected 4", level); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf: got %0h expected 0", ovf); end
    repeat (SD) tick();
    ts_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ts_data !== exp[i]) begin n_fail++; $display("FAIL fullpp_pop%0d: got %0h expected %0h", i, ts_data, exp[i]); end
      tick();
    end
    ts_ready = 1'b0;
  endtask

  task automatic test_clr_with_drop();
    for (int i = 0; i < 6; i++) pulse(32'(i));
    cnt = 32'h99; evt_in = 1'b1;
    repeat (SD) tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; evt_in = 1'b0;
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL clrdrop_ovf: got %0h expected 1", ovf); end
    n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clrdrop_cnt: got %0d expected 1", drop_cnt); end
    repeat (SD) tick();
    drain_all();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
  endtask

  task automatic test_enable_reset();
    cap_en = 1'b0; pulse(32'h77); cap_en = 1'b1;
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL capen_level: got %0d expected 0", level); end
    for (int i = 0; i < 5; i++) pulse(32'h200 + 32'(i));
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL prereset_level: got %0d expected 3", level); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL midreset_level: got %0d expected 0", level); end
    n_tests++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %0h expected 0", ts_valid); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf: got %0h expected 0", ovf); end
    // event held high across reset release yields exactly one capture
    evt_in = 1'b1; reset = 1'b1; tick(); tick(); reset = 1'b0;
    repeat (SD + 4) tick();
    n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL heldreset_level: got %0d expected 1", level); end
    n_tests++; if (ts_data !== mq[0]) begin n_fail++; $display("FAIL heldreset_data: got %0h expected %0h", ts_data, mq[0]); end
    evt_in = 1'b0; repeat (SD) tick();
    drain_all();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 304; i++) pulse(32'(i));
    n_tests++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_drop: got %0h expected ff", drop_cnt); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %0h expected 1", ovf); end
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL sat_level: got %0d expected 4", level); end
  endtask

  task automatic test_random();
    logic [31:0] exp_data;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      evt_in   = ($urandom_range(0, 2) == 0);
      cap_en   = ($urandom_range(0, 7) != 0);
      ts_ready = ((i / 400) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      clr_ovf  = ($urandom_range(0, 40) == 0);
      reset    = ($urandom_range(0, 600) == 0);
      if ($urandom_range(0, 50) == 0) cnt = $urandom();
      if ($urandom_range(0, 200) == 0) cnt = 32'hFFFF_FFFE;
      tick();
      exp_data = (mq.size() > 0) ? mq[0] : 32'd0;
      n_tests++; if (ts_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0h expected %0h", i, ts_valid, mq.size() > 0); end
      n_tests++; if (level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", i, level, mq.size()); end
      n_tests++; if (ts_data !== exp_data) begin n_fail++; $display("FAIL rnd_data@%0d: got %0h expected %0h", i, ts_data, exp_data); end
      n_tests++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %0h expected %0h", i, ovf, m_ovf); end
      n_tests++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d expected %0d", i, drop_cnt, m_drop); end
    end
    reset = 1'b0; evt_in = 1'b0; cap_en = 1'b1; ts_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    cnt = 32'd0; reset = 1'b1; evt_in = 1'b0; cap_en = 1'b1; ts_ready = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_single_capture();
    test_burst_drain();
    test_overflow();
    test_full_pop_push();
    test_clr_with_drop();
    test_enable_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
